despachante_aprovados: RTL and testbench



---
 rtl/despachante_aprovados_if.sv | 59 +++++
 rtl/despachante_aprovados.sv | 180 ++++++++++++++++++
 tb/tb_despachante_aprovados.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/despachante_aprovados_if.sv
// Channel bundle between the active-node evaluator, the approved-node dispatcher,
// the predecessor memory and the neighbour-visiting unit.
interface despachante_aprovados_if #(
  parameter int NUM_NA          = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5
) ();

  // search control
  logic                            iniciar_in;
  logic [ADDR_WIDTH-1:0]           destino_in;

  // evaluator snapshot
  logic                            aa_pronto_in;
  logic                            aa_tem_aprovado_in;
  logic [NUM_NA-1:0]               aa_aprovado_in;
  logic [ADDR_WIDTH*NUM_NA-1:0]    aa_endereco_in;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in;
  logic [ADDR_WIDTH*NUM_NA-1:0]    aa_anterior_data_in;

  // neighbour-unit channel
  logic                            vizinho_ready_in;
  logic                            da_vizinho_valid_out;
  logic [ADDR_WIDTH-1:0]           da_vizinho_endereco_out;
  logic [DISTANCIA_WIDTH-1:0]      da_vizinho_distancia_out;

  // predecessor-memory write port
  logic                            da_anterior_wr_en_out;
  logic [ADDR_WIDTH-1:0]           da_anterior_addr_out;
  logic [ADDR_WIDTH-1:0]           da_anterior_data_out;

  // status back to the evaluator / controller
  logic                            da_remover_aprovados_out;
  logic                            da_encontrado_out;
  logic                            da_ocupado_out;

  // The dispatcher itself.
  modport slave (
    input  iniciar_in, destino_in,
    input  aa_pronto_in, aa_tem_aprovado_in, aa_aprovado_in,
    input  aa_endereco_in, aa_distancia_in, aa_anterior_data_in,
    input  vizinho_ready_in,
    output da_vizinho_valid_out, da_vizinho_endereco_out, da_vizinho_distancia_out,
    output da_anterior_wr_en_out, da_anterior_addr_out, da_anterior_data_out,
    output da_remover_aprovados_out, da_encontrado_out, da_ocupado_out
  );

  // The surrounding datapath that feeds and consumes it.
  modport master (
    output iniciar_in, destino_in,
    output aa_pronto_in, aa_tem_aprovado_in, aa_aprovado_in,
    output aa_endereco_in, aa_distancia_in, aa_anterior_data_in,
    output vizinho_ready_in,
    input  da_vizinho_valid_out, da_vizinho_endereco_out, da_vizinho_distancia_out,
    input  da_anterior_wr_en_out, da_anterior_addr_out, da_anterior_data_out,
    input  da_remover_aprovados_out, da_encontrado_out, da_ocupado_out
  );

endinterface

// File: rtl/despachante_aprovados.sv
// Serialises the evaluator's approved slots (lowest index first): writes each node's
// predecessor, offers it to the neighbour unit, then asks the evaluator to drop them.
module despachante_aprovados #(
  parameter int NUM_NA          = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  despachante_aprovados_if.slave  bus
);

  localparam int IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

  typedef enum logic [2:0] {
    OCIOSO,
    GRAVAR,
    ENVIAR,
    REMOVER,
    ESPERA
  } estado_t;

  estado_t                           r_state;
  logic [NUM_NA-1:0]                 r_pendente;
  logic [ADDR_WIDTH*NUM_NA-1:0]      r_endereco;
  logic [DISTANCIA_WIDTH*NUM_NA-1:0] r_distancia;
  logic [ADDR_WIDTH*NUM_NA-1:0]      r_anterior;

  logic                              r_wr_en;
  logic [ADDR_WIDTH-1:0]             r_wr_addr;
  logic [ADDR_WIDTH-1:0]             r_wr_data;
  logic                              r_vizinho_valid;
  logic [ADDR_WIDTH-1:0]             r_vizinho_endereco;
  logic [DISTANCIA_WIDTH-1:0]        r_vizinho_distancia;
  logic                              r_remover;
  logic                              r_encontrado;

  logic [ADDR_WIDTH-1:0]             w_in_endereco  [NUM_NA];
  logic [ADDR_WIDTH-1:0]             w_in_anterior  [NUM_NA];
  logic [ADDR_WIDTH-1:0]             w_sl_endereco  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0]        w_sl_distancia [NUM_NA];
  logic [ADDR_WIDTH-1:0]             w_sl_anterior  [NUM_NA];

  logic [IDX_W-1:0]                  w_cap_idx;
  logic [IDX_W-1:0]                  w_idx;
  logic [IDX_W-1:0]                  w_prox_idx;
  logic [NUM_NA-1:0]                 w_resto;
  logic                              w_eh_destino;

  function automatic logic [IDX_W-1:0] f_menor_bit(input logic [NUM_NA-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_NA - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Per-slot views of both the live inputs (for capture) and the captured snapshot.
  for (genvar gi = 0; gi < NUM_NA; gi++) begin : g_slot
    assign w_in_endereco[gi]  = bus.aa_endereco_in[ADDR_WIDTH*gi +: ADDR_WIDTH];
    assign w_in_anterior[gi]  = bus.aa_anterior_data_in[ADDR_WIDTH*gi +: ADDR_WIDTH];
    assign w_sl_endereco[gi]  = r_endereco[ADDR_WIDTH*gi +: ADDR_WIDTH];
    assign w_sl_distancia[gi] = r_distancia[DISTANCIA_WIDTH*gi +: DISTANCIA_WIDTH];
    assign w_sl_anterior[gi]  = r_anterior[ADDR_WIDTH*gi +: ADDR_WIDTH];
  end

  assign w_cap_idx    = f_menor_bit(bus.aa_aprovado_in);
  assign w_idx        = f_menor_bit(r_pendente);
  assign w_resto      = r_pendente & ~(NUM_NA'(1) << w_idx);
  assign w_prox_idx   = f_menor_bit(w_resto);
  assign w_eh_destino = (w_sl_endereco[w_idx] == bus.destino_in);

  // Outputs are registered together with the state so each one lines up with the
  // state it belongs to (write during GRAVAR, offer during ENVIAR, pulse in REMOVER).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= OCIOSO;
      r_pendente          <= '0;
      r_endereco          <= '0;
      r_distancia         <= '0;
      r_anterior          <= '0;
      r_wr_en             <= 1'b0;
      r_wr_addr           <= '0;
      r_wr_data           <= '0;
      r_vizinho_valid     <= 1'b0;
      r_vizinho_endereco  <= '0;
      r_vizinho_distancia <= '0;
      r_remover           <= 1'b0;
      r_encontrado        <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_remover <= 1'b0;
      if (bus.iniciar_in) begin
        r_state         <= OCIOSO;
        r_pendente      <= '0;
        r_encontrado    <= 1'b0;
        r_vizinho_valid <= 1'b0;
      end else begin
        case (r_state)
          OCIOSO: begin
            if (bus.aa_pronto_in && bus.aa_tem_aprovado_in) begin
              r_pendente  <= bus.aa_aprovado_in;
              r_endereco  <= bus.aa_endereco_in;
              r_distancia <= bus.aa_distancia_in;
              r_anterior  <= bus.aa_anterior_data_in;
              if (|bus.aa_aprovado_in) begin
                r_state   <= GRAVAR;
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_in_endereco[w_cap_idx];
                r_wr_data <= w_in_anterior[w_cap_idx];
              end else begin
                // Flag said "approved" but the bitmap is empty: just release the evaluator.
                r_state   <= REMOVER;
                r_remover <= 1'b1;
              end
            end
          end

          GRAVAR: begin
            if (w_eh_destino) begin
              r_encontrado <= 1'b1;
              r_pendente   <= w_resto;
              if (|w_resto) begin
                r_state   <= GRAVAR;
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_sl_endereco[w_prox_idx];
                r_wr_data <= w_sl_anterior[w_prox_idx];
              end else begin
                r_state   <= REMOVER;
                r_remover <= 1'b1;
              end
            end else begin
              r_state             <= ENVIAR;
              r_vizinho_valid     <= 1'b1;
              r_vizinho_endereco  <= w_sl_endereco[w_idx];
              r_vizinho_distancia <= w_sl_distancia[w_idx];
            end
          end

          ENVIAR: begin
            if (bus.vizinho_ready_in) begin
              r_vizinho_valid <= 1'b0;
              r_pendente      <= w_resto;
              if (|w_resto) begin
                r_state   <= GRAVAR;
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_sl_endereco[w_prox_idx];
                r_wr_data <= w_sl_anterior[w_prox_idx];
              end else begin
                r_state   <= REMOVER;
                r_remover <= 1'b1;
              end
            end
          end

          REMOVER: r_state <= ESPERA;

          // Dead cycle so the evaluator's removal settles before the next capture.
          ESPERA:  r_state <= OCIOSO;

          default: r_state <= OCIOSO;
        endcase
      end
    end
  end

  assign bus.da_anterior_wr_en_out    = r_wr_en;
  assign bus.da_anterior_addr_out     = r_wr_addr;
  assign bus.da_anterior_data_out     = r_wr_data;
  assign bus.da_vizinho_valid_out     = r_vizinho_valid;
  assign bus.da_vizinho_endereco_out  = r_vizinho_endereco;
  assign bus.da_vizinho_distancia_out = r_vizinho_distancia;
  assign bus.da_remover_aprovados_out = r_remover;
  assign bus.da_encontrado_out        = r_encontrado;
  assign bus.da_ocupado_out           = (r_state != OCIOSO);

endmodule

// File: tb/tb_despachante_aprovados.sv
// Directed bench for despachante_aprovados: cycle-exact checks of writes, offers,
// remover pulse, found flag, iniciar abort and asynchronous reset.
module tb_despachante_aprovados;

  localparam int NA = 4;
  localparam int AW = 5;
  localparam int DW = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  despachante_aprovados_if #(.NUM_NA(NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW)) bus ();

  despachante_aprovados #(.NUM_NA(NA), .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [AW-1:0] e, input logic [DW-1:0] d,
                          input logic [AW-1:0] a);
    bus.aa_endereco_in[AW*s +: AW]      = e;
    bus.aa_distancia_in[DW*s +: DW]     = d;
    bus.aa_anterior_data_in[AW*s +: AW] = a;
  endtask

  task automatic clear_slots();
    bus.aa_endereco_in      = '0;
    bus.aa_distancia_in     = '0;
    bus.aa_anterior_data_in = '0;
  endtask

  // Capture edge happens inside; returns one sample point into cycle T+1.
  task automatic capturar(input logic [NA-1:0] bitmap);
    bus.aa_aprovado_in     = bitmap;
    bus.aa_pronto_in       = 1'b1;
    bus.aa_tem_aprovado_in = 1'b1;
    tick();
    bus.aa_pronto_in       = 1'b0;
    bus.aa_tem_aprovado_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},  32'(bus.da_anterior_wr_en_out), 0);
    chk({tag, "_addr"},   32'(bus.da_anterior_addr_out), 0);
    chk({tag, "_data"},   32'(bus.da_anterior_data_out), 0);
    chk({tag, "_valid"},  32'(bus.da_vizinho_valid_out), 0);
    chk({tag, "_end"},    32'(bus.da_vizinho_endereco_out), 0);
    chk({tag, "_dist"},   32'(bus.da_vizinho_distancia_out), 0);
    chk({tag, "_rem"},    32'(bus.da_remover_aprovados_out), 0);
    chk({tag, "_enc"},    32'(bus.da_encontrado_out), 0);
    chk({tag, "_ocup"},   32'(bus.da_ocupado_out), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr, n_of, n_rm, rm_cyc, idle_cyc;
    logic [AW-1:0] wr_a [3];
    logic [AW-1:0] wr_d [3];
    logic [AW-1:0] of_a [3];
    logic [DW-1:0] of_d [3];

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.iniciar_in         = 1'b0;
    bus.destino_in         = 5'd31;
    bus.aa_pronto_in       = 1'b0;
    bus.aa_tem_aprovado_in = 1'b0;
    bus.aa_aprovado_in     = '0;
    bus.vizinho_ready_in   = 1'b1;
    clear_slots();

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    #3 rst_n = 1'b1;
    tick();
    chk("post_reset_ocup", 32'(bus.da_ocupado_out), 0);

    // Single approved node, ready high
    set_slot(2, 5'd9, 5'd7, 5'd3);
    capturar(4'b0100);
    chk("s1_t1_wr_en", 32'(bus.da_anterior_wr_en_out), 1);
    chk("s1_t1_addr",  32'(bus.da_anterior_addr_out), 9);
    chk("s1_t1_data",  32'(bus.da_anterior_data_out), 3);
    chk("s1_t1_valid", 32'(bus.da_vizinho_valid_out), 0);
    chk("s1_t1_ocup",  32'(bus.da_ocupado_out), 1);
    tick();
    chk("s1_t2_wr_en", 32'(bus.da_anterior_wr_en_out), 0);
    chk("s1_t2_valid", 32'(bus.da_vizinho_valid_out), 1);
    chk("s1_t2_end",   32'(bus.da_vizinho_endereco_out), 9);
    chk("s1_t2_dist",  32'(bus.da_vizinho_distancia_out), 7);
    tick();
    chk("s1_t3_valid", 32'(bus.da_vizinho_valid_out), 0);
    chk("s1_t3_rem",   32'(bus.da_remover_aprovados_out), 1);
    tick();
    chk("s1_t4_rem",   32'(bus.da_remover_aprovados_out), 0);
    chk("s1_t4_ocup",  32'(bus.da_ocupado_out), 1);
    tick();
    chk("s1_t5_ocup",  32'(bus.da_ocupado_out), 0);
    chk("s1_t5_enc",   32'(bus.da_encontrado_out), 0);

    // Ordering: bitmap 1011, slot 2 holds decoy values
    clear_slots();
    set_slot(0, 5'd1, 5'd20, 5'd10);
    set_slot(1, 5'd2, 5'd21, 5'd11);
    set_slot(2, 5'd3, 5'd22, 5'd12);
    set_slot(3, 5'd4, 5'd23, 5'd13);
    n_wr = 0; n_of = 0; n_rm = 0; rm_cyc = 0; idle_cyc = 0;
    capturar(4'b1011);
    for (int k = 1; k <= 9; k++) begin
      if (bus.da_anterior_wr_en_out) begin
        if (n_wr < 3) begin
          wr_a[n_wr] = bus.da_anterior_addr_out;
          wr_d[n_wr] = bus.da_anterior_data_out;
        end
        n_wr++;
      end
      if (bus.da_vizinho_valid_out && bus.vizinho_ready_in) begin
        if (n_of < 3) begin
          of_a[n_of] = bus.da_vizinho_endereco_out;
          of_d[n_of] = bus.da_vizinho_distancia_out;
        end
        n_of++;
      end
      if (bus.da_remover_aprovados_out) begin
        n_rm++;
        rm_cyc = k;
      end
      if (!bus.da_ocupado_out && idle_cyc == 0) idle_cyc = k;
      tick();
    end
    chk("s2_n_wr", 32'(n_wr), 3);
    chk("s2_n_of", 32'(n_of), 3);
    if (n_wr >= 3 && n_of >= 3) begin
      chk("s2_wr_a0", 32'(wr_a[0]), 1);
      chk("s2_wr_a1", 32'(wr_a[1]), 2);
      chk("s2_wr_a2", 32'(wr_a[2]), 4);
      chk("s2_wr_d2", 32'(wr_d[2]), 13);
      chk("s2_of_a0", 32'(of_a[0]), 1);
      chk("s2_of_a1", 32'(of_a[1]), 2);
      chk("s2_of_a2", 32'(of_a[2]), 4);
      chk("s2_of_d1", 32'(of_d[1]), 21);
    end
    chk("s2_n_rm",    32'(n_rm), 1);
    chk("s2_rm_cyc",  32'(rm_cyc), 7);
    chk("s2_idle",    32'(idle_cyc), 9);

    // Backpressure: ready low 5 cycles; later input changes must be ignored
    clear_slots();
    set_slot(0, 5'd5, 5'd6, 5'd8);
    bus.vizinho_ready_in = 1'b0;
    capturar(4'b0001);
    chk("s3_t1_wr_en", 32'(bus.da_anterior_wr_en_out), 1);
    chk("s3_t1_addr",  32'(bus.da_anterior_addr_out), 5);
    chk("s3_t1_data",  32'(bus.da_anterior_data_out), 8);
    set_slot(0, 5'd17, 5'd17, 5'd17);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("s3_valid", 32'(bus.da_vizinho_valid_out), 1);
      chk("s3_end",   32'(bus.da_vizinho_endereco_out), 5);
      chk("s3_dist",  32'(bus.da_vizinho_distancia_out), 6);
      chk("s3_wr_en", 32'(bus.da_anterior_wr_en_out), 0);
      chk("s3_rem",   32'(bus.da_remover_aprovados_out), 0);
      if (k == 5) bus.vizinho_ready_in = 1'b1;
      tick();
    end
    chk("s3_after_valid", 32'(bus.da_vizinho_valid_out), 0);
    chk("s3_after_rem",   32'(bus.da_remover_aprovados_out), 1);
    chk("s3_after_wr",    32'(bus.da_anterior_wr_en_out), 0);
    tick();
    tick();
    chk("s3_idle", 32'(bus.da_ocupado_out), 0);

    // Destination approved in slot 0
    clear_slots();
    bus.destino_in = 5'd12;
    set_slot(0, 5'd12, 5'd4, 5'd2);
    set_slot(1, 5'd14, 5'd5, 5'd6);
    capturar(4'b0011);
    chk("s4_t1_wr_en", 32'(bus.da_anterior_wr_en_out), 1);
    chk("s4_t1_addr",  32'(bus.da_anterior_addr_out), 12);
    chk("s4_t1_data",  32'(bus.da_anterior_data_out), 2);
    chk("s4_t1_enc",   32'(bus.da_encontrado_out), 0);
    tick();
    chk("s4_t2_enc",   32'(bus.da_encontrado_out), 1);
    chk("s4_t2_valid", 32'(bus.da_vizinho_valid_out), 0);
    chk("s4_t2_wr_en", 32'(bus.da_anterior_wr_en_out), 1);
    chk("s4_t2_addr",  32'(bus.da_anterior_addr_out), 14);
    chk("s4_t2_data",  32'(bus.da_anterior_data_out), 6);
    tick();
    chk("s4_t3_valid", 32'(bus.da_vizinho_valid_out), 1);
    chk("s4_t3_end",   32'(bus.da_vizinho_endereco_out), 14);
    chk("s4_t3_dist",  32'(bus.da_vizinho_distancia_out), 5);
    tick();
    chk("s4_t4_rem",   32'(bus.da_remover_aprovados_out), 1);
    tick();
    tick();
    chk("s4_t6_ocup",  32'(bus.da_ocupado_out), 0);
    chk("s4_t6_enc",   32'(bus.da_encontrado_out), 1);

    // iniciar_in while offering
    clear_slots();
    bus.destino_in = 5'd31;
    set_slot(0, 5'd7, 5'd1, 5'd0);
    bus.vizinho_ready_in = 1'b0;
    capturar(4'b0001);
    tick();
    chk("s5_t2_valid", 32'(bus.da_vizinho_valid_out), 1);
    bus.iniciar_in = 1'b1;
    tick();
    bus.iniciar_in = 1'b0;
    chk("s5_t3_valid", 32'(bus.da_vizinho_valid_out), 0);
    chk("s5_t3_enc",   32'(bus.da_encontrado_out), 0);
    chk("s5_t3_rem",   32'(bus.da_remover_aprovados_out), 0);
    chk("s5_t3_ocup",  32'(bus.da_ocupado_out), 0);
    tick();
    chk("s5_t4_rem",   32'(bus.da_remover_aprovados_out), 0);
    chk("s5_t4_ocup",  32'(bus.da_ocupado_out), 0);
    chk("s5_t4_wr_en", 32'(bus.da_anterior_wr_en_out), 0);

    // Asynchronous reset while offering, found flag set
    clear_slots();
    bus.destino_in = 5'd12;
    set_slot(0, 5'd12, 5'd4, 5'd2);
    set_slot(1, 5'd14, 5'd5, 5'd6);
    capturar(4'b0011);
    tick();
    tick();
    chk("s6_pre_valid", 32'(bus.da_vizinho_valid_out), 1);
    chk("s6_pre_enc",   32'(bus.da_encontrado_out), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("s6_async");
    tick();
    #3 rst_n = 1'b1;
    tick();
    clear_slots();
    bus.destino_in = 5'd31;
    bus.vizinho_ready_in = 1'b1;
    set_slot(2, 5'd9, 5'd7, 5'd3);
    capturar(4'b0100);
    chk("s6_cap_wr_en", 32'(bus.da_anterior_wr_en_out), 1);
    chk("s6_cap_addr",  32'(bus.da_anterior_addr_out), 9);
    chk("s6_cap_data",  32'(bus.da_anterior_data_out), 3);
    tick();
    chk("s6_cap_valid", 32'(bus.da_vizinho_valid_out), 1);
    chk("s6_cap_end",   32'(bus.da_vizinho_endereco_out), 9);
    tick();
    chk("s6_cap_rem",   32'(bus.da_remover_aprovados_out), 1);
    tick();
    tick();
    chk("s6_cap_idle",  32'(bus.da_ocupado_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
